// File: rtl/fpga_temp_monitor.sv
// Temperature monitor for an FPGA die sensor: moving average over a circular
// window, min/max tracking, and a debounced over-temperature alarm with hysteresis.
module fpga_temp_monitor #(
   parameter int         AVG_DEPTH      = 4,
   parameter logic [7:0] HIGH_THRESHOLD = 8'd200,
   parameter logic [7:0] LOW_THRESHOLD  = 8'd180,
   parameter int         ALARM_COUNT    = 3
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic [7:0] i_Temperature,
   input  logic       i_TempValid,
   input  logic       i_ClearMinMax,
   output logic [7:0] o_AvgTemp,
   output logic       o_AvgValid,
   output logic [7:0] o_MinTemp,
   output logic [7:0] o_MaxTemp,
   output logic       o_Ready,
   output logic       o_Alarm
);

   localparam int PTR_W = $clog2(AVG_DEPTH);
   localparam int SUM_W = 8 + PTR_W;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(AVG_DEPTH);

   typedef enum logic [1:0] {
      ST_NORMAL,
      ST_PENDING,
      ST_ALARM
   } state_t;

   logic [7:0]       buf_q [AVG_DEPTH];
   logic [7:0]       buf_d [AVG_DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] fill_q, fill_d;
   logic             ready_q, ready_d;
   logic [7:0]       avg_q, avg_d;
   logic             avg_valid_q, avg_valid_d;
   logic [7:0]       min_q, min_d;
   logic [7:0]       max_q, max_d;
   logic             first_q, first_d;
   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;

   // Averaging window, fill tracking and min/max.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      buf_d       = buf_q;
      ptr_d       = ptr_q;
      sum_d       = sum_q;
      fill_d      = fill_q;
      ready_d     = ready_q;
      avg_d       = avg_q;
      avg_valid_d = 1'b0;
      min_d       = min_q;
      max_d       = max_q;
      first_d     = first_q;

      if (i_TempValid) begin
         // The overwritten entry is already part of sum_q, so this cannot overflow.
         sum_d        = sum_q + SUM_W'(i_Temperature) - SUM_W'(buf_q[ptr_q]);
         buf_d[ptr_q] = i_Temperature;
         ptr_d        = ptr_q + PTR_W'(1);
         if (fill_q != FILL_MAX) begin
            fill_d = fill_q + CNT_W'(1);
         end
         if (ready_q || (fill_q == FILL_MAX - CNT_W'(1))) begin
            ready_d     = 1'b1;
            avg_valid_d = 1'b1;
            avg_d       = sum_d[SUM_W-1:PTR_W];
         end
      end

      if (i_TempValid) begin
         if (first_q || i_ClearMinMax) begin
            min_d   = i_Temperature;
            max_d   = i_Temperature;
            first_d = 1'b0;
         end else begin
            if (i_Temperature < min_q) min_d = i_Temperature;
            if (i_Temperature > max_q) max_d = i_Temperature;
         end
      end else if (i_ClearMinMax) begin
         min_d   = 8'hFF;
         max_d   = 8'h00;
         first_d = 1'b1;
      end
   end

   always_ff @(posedge i_Clk) begin
      // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
      if (i_Rst) begin
         // NOTE: the window memory is cleared too, so the running sum stays consistent with it.
         for (int i = 0; i < AVG_DEPTH; i++) buf_q[i] <= '0;
         ptr_q       <= '0;
         sum_q       <= '0;
         fill_q      <= '0;
         ready_q     <= 1'b0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
         min_q       <= 8'hFF;
         max_q       <= 8'h00;
         first_q     <= 1'b1;
      end else begin
         for (int i = 0; i < AVG_DEPTH; i++) buf_q[i] <= buf_d[i];
         ptr_q       <= ptr_d;
         sum_q       <= sum_d;
         fill_q      <= fill_d;
         ready_q     <= ready_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
         min_q       <= min_d;
         max_q       <= max_d;
         first_q     <= first_d;
      end
   end

   // Alarm FSM: state register.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q <= ST_NORMAL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Alarm FSM: next state, evaluated only on fresh averages.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (avg_valid_q) begin
         unique case (state_q)
            ST_NORMAL: begin
               if (avg_q >= HIGH_THRESHOLD) begin
                  cnt_d   = 4'd1;
                  state_d = (ALARM_COUNT == 1) ? ST_ALARM : ST_PENDING;
               end
            end
            ST_PENDING: begin
               if (avg_q >= HIGH_THRESHOLD) begin
                  cnt_d = cnt_q + 4'd1;
                  if ((cnt_q + 4'd1) >= 4'(ALARM_COUNT)) state_d = ST_ALARM;
               end else begin
                  cnt_d   = '0;
                  state_d = ST_NORMAL;
               end
            end
            ST_ALARM: begin
               // Between the thresholds the alarm holds.
               if (avg_q <= LOW_THRESHOLD) begin
                  cnt_d   = '0;
                  state_d = ST_NORMAL;
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = ST_NORMAL;
            end
         endcase
      end
   end

   // Alarm FSM: outputs.
   always_comb begin
      o_Alarm = (state_q == ST_ALARM);
   end

   assign o_AvgTemp  = avg_q;
   assign o_AvgValid = avg_valid_q;
   assign o_MinTemp  = min_q;
   assign o_MaxTemp  = max_q;
   assign o_Ready    = ready_q;

endmodule

// File: tb/tb_fpga_temp_monitor.sv
// Directed bench for fpga_temp_monitor: fill, wrap, min/max, alarm debounce and
// hysteresis, mid-stream reset and idle hold, with hand-computed expectations.
module tb_fpga_temp_monitor;

   logic       i_Clk = 1'b0;
   logic       i_Rst = 1'b1;
   logic [7:0] i_Temperature = 8'd0;
   logic       i_TempValid = 1'b0;
   logic       i_ClearMinMax = 1'b0;
   logic [7:0] o_AvgTemp;
   logic       o_AvgValid;
   logic [7:0] o_MinTemp;
   logic [7:0] o_MaxTemp;
   logic       o_Ready;
   logic       o_Alarm;

   int vectors    = 0;
   int miscompares = 0;

   fpga_temp_monitor dut (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_Temperature(i_Temperature),
      .i_TempValid  (i_TempValid),
      .i_ClearMinMax(i_ClearMinMax),
      .o_AvgTemp    (o_AvgTemp),
      .o_AvgValid   (o_AvgValid),
      .o_MinTemp    (o_MinTemp),
      .o_MaxTemp    (o_MaxTemp),
      .o_Ready      (o_Ready),
      .o_Alarm      (o_Alarm)
   );

   always #5 i_Clk = ~i_Clk;

   // Present inputs for one rising edge; returns at the following falling edge,
   // where that edge's results are visible.
   task automatic cycle(input logic v, input logic [7:0] t, input logic c, input logic r);
      i_TempValid   = v;
      i_Temperature = t;
      i_ClearMinMax = c;
      i_Rst         = r;
      @(negedge i_Clk);
      i_TempValid   = 1'b0;
      i_ClearMinMax = 1'b0;
      i_Rst         = 1'b0;
   endtask

   task automatic test_reset();
      cycle(1'b0, 8'd0, 1'b0, 1'b1);
      cycle(1'b0, 8'd0, 1'b0, 1'b1);
      vectors++; if (o_AvgTemp !== 8'd0) begin miscompares++; $display("FAIL reset_avg: got %0d expected 0", o_AvgTemp); end
      vectors++; if (o_AvgValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", o_AvgValid); end
      vectors++; if (o_MinTemp !== 8'hFF) begin miscompares++; $display("FAIL reset_min: got %0h expected ff", o_MinTemp); end
      vectors++; if (o_MaxTemp !== 8'h00) begin miscompares++; $display("FAIL reset_max: got %0h expected 00", o_MaxTemp); end
      vectors++; if (o_Ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %0b expected 0", o_Ready); end
      vectors++; if (o_Alarm !== 1'b0) begin miscompares++; $display("FAIL reset_alarm: got %0b expected 0", o_Alarm); end
   endtask

   task automatic test_fill();
      logic [7:0] samples [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, samples[i], 1'b0, 1'b0);
         vectors++; if (o_AvgValid !== 1'b0) begin miscompares++; $display("FAIL fill_valid_%0d: got %0b expected 0", i, o_AvgValid); end
         vectors++; if (o_Ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready_%0d: got %0b expected 0", i, o_Ready); end
         cycle(1'b0, 8'd0, 1'b0, 1'b0);
      end
      cycle(1'b1, samples[3], 1'b0, 1'b0);
      vectors++; if (o_AvgValid !== 1'b1) begin miscompares++; $display("FAIL fill_valid_4: got %0b expected 1", o_AvgValid); end
      vectors++; if (o_AvgTemp !== 8'd25) begin miscompares++; $display("FAIL fill_avg: got %0d expected 25", o_AvgTemp); end
      vectors++; if (o_Ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_4: got %0b expected 1", o_Ready); end
      vectors++; if (o_MinTemp !== 8'd10 || o_MaxTemp !== 8'd40) begin miscompares++; $display("FAIL fill_minmax: got %0d/%0d expected 10/40", o_MinTemp, o_MaxTemp); end
      cycle(1'b0, 8'd0, 1'b0, 1'b0);
      vectors++; if (o_AvgValid !== 1'b0) begin miscompares++; $display("FAIL fill_pulse_end: got %0b expected 0", o_AvgValid); end
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 8'd50, 1'b0, 1'b0);
      vectors++; if (o_AvgValid !== 1'b1 || o_AvgTemp !== 8'd35) begin miscompares++; $display("FAIL wrap_first: got valid=%0b avg=%0d expected 1/35", o_AvgValid, o_AvgTemp); end
      cycle(1'b1, 8'd60, 1'b0, 1'b0);
      vectors++; if (o_AvgValid !== 1'b1 || o_AvgTemp !== 8'd45) begin miscompares++; $display("FAIL wrap_second: got valid=%0b avg=%0d expected 1/45", o_AvgValid, o_AvgTemp); end
      cycle(1'b0, 8'd0, 1'b0, 1'b0);
      vectors++; if (o_AvgValid !== 1'b0 || o_AvgTemp !== 8'd45) begin miscompares++; $display("FAIL wrap_idle: got valid=%0b avg=%0d expected 0/45", o_AvgValid, o_AvgTemp); end
   endtask

   task automatic test_minmax();
      cycle(1'b0, 8'd0, 1'b1, 1'b0);
      vectors++; if (o_MinTemp !== 8'hFF || o_MaxTemp !== 8'h00) begin miscompares++; $display("FAIL clear_only: got %0h/%0h expected ff/00", o_MinTemp, o_MaxTemp); end
      cycle(1'b1, 8'd100, 1'b0, 1'b0);
      vectors++; if (o_MinTemp !== 8'd100 || o_MaxTemp !== 8'd100) begin miscompares++; $display("FAIL mm_first: got %0d/%0d expected 100/100", o_MinTemp, o_MaxTemp); end
      cycle(1'b1, 8'd50, 1'b0, 1'b0);
      vectors++; if (o_MinTemp !== 8'd50 || o_MaxTemp !== 8'd100) begin miscompares++; $display("FAIL mm_low: got %0d/%0d expected 50/100", o_MinTemp, o_MaxTemp); end
      cycle(1'b1, 8'd150, 1'b0, 1'b0);
      vectors++; if (o_MinTemp !== 8'd50 || o_MaxTemp !== 8'd150) begin miscompares++; $display("FAIL mm_high: got %0d/%0d expected 50/150", o_MinTemp, o_MaxTemp); end
      cycle(1'b1, 8'd77, 1'b1, 1'b0);
      vectors++; if (o_MinTemp !== 8'd77 || o_MaxTemp !== 8'd77) begin miscompares++; $display("FAIL mm_clear_sample: got %0d/%0d expected 77/77", o_MinTemp, o_MaxTemp); end
   endtask

   // Samples chosen so the averages run 210,210,190,210,210,210.
   task automatic test_alarm();
      logic [7:0] samples [9] = '{8'd210, 8'd250, 8'd170, 8'd210, 8'd210, 8'd170, 8'd250, 8'd210, 8'd210};
      logic [7:0] avgs    [9] = '{8'd0, 8'd0, 8'd0, 8'd210, 8'd210, 8'd190, 8'd210, 8'd210, 8'd210};
      cycle(1'b0, 8'd0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         cycle(1'b1, samples[i], 1'b0, 1'b0);
         if (i >= 3) begin
            vectors++; if (o_AvgValid !== 1'b1 || o_AvgTemp !== avgs[i]) begin miscompares++; $display("FAIL alarm_avg_%0d: got valid=%0b avg=%0d expected 1/%0d", i, o_AvgValid, o_AvgTemp, avgs[i]); end
         end
         cycle(1'b0, 8'd0, 1'b0, 1'b0);
         vectors++;
         if (o_Alarm !== (i == 8)) begin miscompares++; $display("FAIL alarm_state_%0d: got %0b expected %0b", i, o_Alarm, (i == 8)); end
      end
      cycle(1'b1, 8'd90, 1'b0, 1'b0);
      vectors++; if (o_AvgTemp !== 8'd190) begin miscompares++; $display("FAIL hyst_avg190: got %0d expected 190", o_AvgTemp); end
      cycle(1'b0, 8'd0, 1'b0, 1'b0);
      vectors++; if (o_Alarm !== 1'b1) begin miscompares++; $display("FAIL hyst_hold: got %0b expected 1", o_Alarm); end
      cycle(1'b1, 8'd210, 1'b0, 1'b0);
      vectors++; if (o_AvgTemp !== 8'd180 || o_Alarm !== 1'b1) begin miscompares++; $display("FAIL hyst_avg180: got avg=%0d alarm=%0b expected 180/1", o_AvgTemp, o_Alarm); end
      cycle(1'b0, 8'd0, 1'b0, 1'b0);
      vectors++; if (o_Alarm !== 1'b0) begin miscompares++; $display("FAIL hyst_clear: got %0b expected 0", o_Alarm); end
   endtask

   task automatic test_reset_mid();
      cycle(1'b0, 8'd0, 1'b0, 1'b1);
      cycle(1'b1, 8'd4, 1'b0, 1'b0);
      cycle(1'b1, 8'd8, 1'b0, 1'b0);
      cycle(1'b1, 8'd12, 1'b0, 1'b0);
      cycle(1'b1, 8'd16, 1'b1, 1'b1);
      vectors++; if (o_AvgValid !== 1'b0 || o_AvgTemp !== 8'd0) begin miscompares++; $display("FAIL rstmid_avg: got valid=%0b avg=%0d expected 0/0", o_AvgValid, o_AvgTemp); end
      vectors++; if (o_MinTemp !== 8'hFF || o_MaxTemp !== 8'h00) begin miscompares++; $display("FAIL rstmid_minmax: got %0h/%0h expected ff/00", o_MinTemp, o_MaxTemp); end
      vectors++; if (o_Ready !== 1'b0 || o_Alarm !== 1'b0) begin miscompares++; $display("FAIL rstmid_flags: got ready=%0b alarm=%0b expected 0/0", o_Ready, o_Alarm); end
      cycle(1'b1, 8'd4, 1'b0, 1'b0);
      cycle(1'b1, 8'd8, 1'b0, 1'b0);
      cycle(1'b1, 8'd12, 1'b0, 1'b0);
      vectors++; if (o_AvgValid !== 1'b0 || o_Ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_refill: got valid=%0b ready=%0b expected 0/0", o_AvgValid, o_Ready); end
      cycle(1'b1, 8'd16, 1'b0, 1'b0);
      vectors++; if (o_AvgValid !== 1'b1 || o_AvgTemp !== 8'd10 || o_Ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_full: got valid=%0b avg=%0d ready=%0b expected 1/10/1", o_AvgValid, o_AvgTemp, o_Ready); end
      vectors++; if (o_MinTemp !== 8'd4 || o_MaxTemp !== 8'd16) begin miscompares++; $display("FAIL rstmid_mm: got %0d/%0d expected 4/16", o_MinTemp, o_MaxTemp); end
   endtask

   task automatic test_idle_hold();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 8'(8'hA5 + i * 40), 1'b0, 1'b0);
         vectors++;
         if (o_AvgValid !== 1'b0 || o_AvgTemp !== 8'd10 || o_MinTemp !== 8'd4 || o_MaxTemp !== 8'd16 || o_Ready !== 1'b1 || o_Alarm !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold_%0d: got v=%0b avg=%0d min=%0d max=%0d rdy=%0b al=%0b expected 0/10/4/16/1/0",
                     i, o_AvgValid, o_AvgTemp, o_MinTemp, o_MaxTemp, o_Ready, o_Alarm);
         end
      end
   endtask

   initial begin
      @(negedge i_Clk);
      test_reset();
      test_fill();
      test_back_to_back();
      test_minmax();
      test_alarm();
      test_reset_mid();
      test_idle_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
